// File: rtl/beat_master.sv
// Burst beat generator: issues len incrementing data beats from seed over valid/data/ready, with optional idle gaps.
// Latency: first valid_out one cycle after an accepted start; one beat per cycle when gap=0 and ready_in=1.
// Backpressure: valid_out/data_out hold while ready_in=0; every output is registered, so none depends combinationally on ready_in.
module beat_master #(
  parameter int DATA_W = 3,
  parameter int LEN_W  = 4,
  parameter int GAP_W  = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] seed,
  input  logic [GAP_W-1:0]  gap,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  sent_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0]  GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [GAP_W-1:0]  gap_q, gap_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              valid_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [LEN_W-1:0]  sent_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              xfer;
  logic [LEN_W-1:0]  sent_inc;
  logic              last_beat;

  // A beat moves on any edge where the registered valid meets the slave's ready.
  assign xfer      = valid_out & ready_in;
  assign sent_inc  = sent_cnt + LEN_ONE;
  assign last_beat = (sent_inc == len_q);

  // Next-state and next-output decode; every target gets a hold default first.
  always_comb begin
    state_nxt   = state;
    len_nxt     = len_q;
    gap_nxt     = gap_q;
    gap_cnt_nxt = gap_cnt;
    valid_nxt   = valid_out;
    data_nxt    = data_out;
    sent_nxt    = sent_cnt;

    case (state)
      S_IDLE: begin
        valid_nxt = 1'b0;
        if (start) begin
          len_nxt  = len;
          gap_nxt  = gap;
          sent_nxt = '0;
          data_nxt = seed;
          if (len == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SEND;
            valid_nxt = 1'b1;
          end
        end
      end

      S_SEND: begin
        // Without a transfer everything holds, which keeps valid/data stable.
        if (xfer) begin
          sent_nxt = sent_inc;
          // data_out advances on every transfer so a gap resumes at previous+1.
          data_nxt = data_out + DATA_ONE;
          if (last_beat) begin
            state_nxt = S_DONE;
            valid_nxt = 1'b0;
          end else if (gap_q == '0) begin
            valid_nxt = 1'b1;
          end else begin
            state_nxt   = S_GAP;
            valid_nxt   = 1'b0;
            gap_cnt_nxt = gap_q - GAP_ONE;
          end
        end
      end

      S_GAP: begin
        // gap_cnt counts down the remaining idle cycles after this one.
        valid_nxt = 1'b0;
        if (gap_cnt == '0) begin
          state_nxt = S_SEND;
          valid_nxt = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_ONE;
        end
      end

      S_DONE: begin
        // Completion cycle; start is not looked at here, only from IDLE.
        valid_nxt = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        valid_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

  // State, captured burst parameters and registered outputs; reset clears all immediately.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sent_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      len_q     <= len_nxt;
      gap_q     <= gap_nxt;
      gap_cnt   <= gap_cnt_nxt;
      valid_out <= valid_nxt;
      data_out  <= data_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      sent_cnt  <= sent_nxt;
    end
  end

endmodule

// File: tb/tb_beat_master.sv
// Directed bench for beat_master: per-cycle vector table plus reset and random-backpressure sequences.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
// The downstream slave is modelled here as a collector that records every beat it accepts.
module tb_beat_master;

  logic       sys_clk;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic [2:0] seed;
  logic [1:0] gap;
  logic       ready_in;
  logic       valid_out;
  logic [2:0] data_out;
  logic       busy;
  logic       done;
  logic [3:0] sent_cnt;

  int checks = 0;
  int errors = 0;

  beat_master #(.DATA_W(3), .LEN_W(4), .GAP_W(2)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .seed     (seed),
    .gap      (gap),
    .ready_in (ready_in),
    .valid_out(valid_out),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .sent_cnt (sent_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       st;
    logic [3:0] l;
    logic [2:0] s;
    logic [1:0] g;
    logic       r;
    logic       ev;
    logic [2:0] ed;
    logic       eb;
    logic       edn;
    logic [3:0] es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [3:0] l, input logic [2:0] s,
                              input logic [1:0] g, input logic r, input logic ev,
                              input logic [2:0] ed, input logic eb, input logic edn,
                              input logic [3:0] es);
    vec_t v;
    v.st = st; v.l = l; v.s = s; v.g = g; v.r = r;
    v.ev = ev; v.ed = ed; v.eb = eb; v.edn = edn; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [2:0] ed,
                          input logic eb, input logic edn, input logic [3:0] es);
    chk({tag, ".valid"}, int'(valid_out), int'(ev));
    chk({tag, ".busy"},  int'(busy),      int'(eb));
    chk({tag, ".done"},  int'(done),      int'(edn));
    chk({tag, ".sent"},  int'(sent_cnt),  int'(es));
    if (ev) chk({tag, ".data"}, int'(data_out), int'(ed));
  endtask

  task automatic drive(input logic st, input logic [3:0] l, input logic [2:0] s,
                       input logic [1:0] g, input logic r);
    start = st; len = l; seed = s; gap = g; ready_in = r;
  endtask

  logic [2:0] got[$];
  logic       prev_stall;
  logic [2:0] prev_data;
  logic [2:0] exp_d;
  int         done_cnt;

  initial begin
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    chk_outs("reset", 0, 0, 0, 0, 0);
    chk("reset.data", int'(data_out), 0);

    // columns: start len seed gap ready | valid data busy done sent
    // burst len=3 seed=2 gap=0, ready always high
    vecs.push_back(mk(1, 3, 2, 0, 1,  1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 3, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 4, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 1, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 3));
    // same burst, ready low for two cycles on the first beat; start in SEND and DONE ignored
    vecs.push_back(mk(1, 3, 2, 0, 0,  1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 3, 1, 0, 1));
    vecs.push_back(mk(1, 1, 5, 0, 1,  1, 4, 1, 0, 2));
    vecs.push_back(mk(1, 1, 5, 0, 1,  0, 0, 1, 1, 3));
    vecs.push_back(mk(1, 1, 5, 0, 1,  0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 3));
    // len=4 seed=6 gap=2: 6,7,0,1 with two idle cycles between beats; ready toggles in GAP
    vecs.push_back(mk(1, 4, 6, 2, 1,  1, 6, 1, 0, 0));
    vecs.push_back(mk(0, 0, 7, 0, 1,  0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 7, 0, 0,  0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 7, 0, 1,  1, 7, 1, 0, 1));
    vecs.push_back(mk(0, 0, 7, 0, 1,  0, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 7, 0, 1,  0, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 7, 0, 1,  1, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 7, 0, 1,  0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 7, 0, 0,  0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 7, 0, 0,  1, 1, 1, 0, 3));
    vecs.push_back(mk(0, 0, 7, 0, 1,  0, 0, 1, 1, 4));
    vecs.push_back(mk(0, 0, 7, 0, 1,  0, 0, 0, 0, 4));
    // len=0: straight to DONE
    vecs.push_back(mk(1, 0, 5, 3, 1,  0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    // len=2 burst with a len=5 start re-asserted mid-burst
    vecs.push_back(mk(1, 2, 3, 0, 0,  1, 3, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 1,  1, 4, 1, 0, 1));
    vecs.push_back(mk(1, 5, 0, 0, 1,  0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 2));

    @(negedge sys_clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge sys_clk);
      drive(vecs[i].st, vecs[i].l, vecs[i].s, vecs[i].g, vecs[i].r);
      @(posedge sys_clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eb, vecs[i].edn, vecs[i].es);
    end

    // reset after two of five beats: outputs clear without waiting for a clock edge
    @(negedge sys_clk);
    drive(1, 5, 1, 0, 1);
    @(posedge sys_clk); #1;
    chk_outs("rb.first", 1, 1, 1, 0, 0);
    @(negedge sys_clk);
    drive(0, 0, 0, 0, 1);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk_outs("rb.two", 1, 3, 1, 0, 2);
    #2 rst = 1'b1;
    #1;
    chk_outs("rb.async", 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      chk_outs($sformatf("rb.quiet%0d", i), 0, 0, 0, 0, 0);
    end
    @(negedge sys_clk);
    drive(1, 2, 0, 0, 1);
    @(posedge sys_clk); #1;
    chk_outs("rb.new0", 1, 0, 1, 0, 0);
    @(negedge sys_clk);
    drive(0, 0, 0, 0, 1);
    @(posedge sys_clk); #1;
    chk_outs("rb.new1", 1, 1, 1, 0, 1);
    @(posedge sys_clk); #1;
    chk_outs("rb.new2", 0, 0, 1, 1, 2);
    @(posedge sys_clk); #1;
    chk_outs("rb.new3", 0, 0, 0, 0, 2);

    // len=15 into a collector with random 50% ready for 200 cycles
    got.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    done_cnt   = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge sys_clk);
      if (c == 0) drive(1, 15, 5, 0, 1'($urandom_range(0, 1)));
      else        drive(0, 0, 0, 0, 1'($urandom_range(0, 1)));
      #1;
      if (prev_stall) begin
        chk("rnd.hold_valid", int'(valid_out), 1);
        chk("rnd.hold_data", int'(data_out), int'(prev_data));
      end
      if (valid_out && ready_in) got.push_back(data_out);
      if (done) done_cnt++;
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
    end
    chk("rnd.count", got.size(), 15);
    for (int i = 0; i < got.size() && i < 15; i++) begin
      exp_d = 3'(5 + i);
      chk($sformatf("rnd.beat%0d", i), int'(got[i]), int'(exp_d));
    end
    chk("rnd.done_pulses", done_cnt, 1);
    chk("rnd.sent", int'(sent_cnt), 15);
    chk("rnd.busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
